// File: rtl/menu_select_controller_pkg.sv
// Shared option/screen codes, button event indices and metadata field layout for the main menu.
package menu_pkg;

  localparam logic [2:0] OPT_PLAY1P  = 3'd0;
  localparam logic [2:0] OPT_ENDLESS = 3'd1;
  localparam logic [2:0] OPT_PLAY2P  = 3'd2;
  localparam logic [2:0] OPT_TOP1P   = 3'd3;
  localparam logic [2:0] OPT_TOPEND  = 3'd4;

  localparam logic [2:0] SCR_MENU   = 3'd0;
  localparam logic [2:0] SCR_GAME   = 3'd1;
  localparam logic [2:0] SCR_SCORES = 3'd2;

  localparam int MD_WIDTH      = 29;
  localparam int MD_CURSOR_LSB = 26;
  localparam int MD_SCREEN_LSB = 23;

  // Event index doubles as priority: lower index wins.
  localparam int NUM_BTN = 6;
  localparam logic [2:0] EV_UP     = 3'd0;
  localparam logic [2:0] EV_DOWN   = 3'd1;
  localparam logic [2:0] EV_LEFT   = 3'd2;
  localparam logic [2:0] EV_RIGHT  = 3'd3;
  localparam logic [2:0] EV_SELECT = 3'd4;
  localparam logic [2:0] EV_BACK   = 3'd5;

  typedef enum logic [1:0] {ST_MENU, ST_LAUNCH, ST_RUN, ST_SCORES} menuState_e;

  function automatic logic [2:0] screenOf(input menuState_e st);
    case (st)
      ST_LAUNCH, ST_RUN: screenOf = SCR_GAME;
      ST_SCORES:         screenOf = SCR_SCORES;
      default:           screenOf = SCR_MENU;
    endcase
  endfunction

  function automatic logic [2:0] moveCursor(input logic [2:0] cur, input logic [2:0] ev);
    logic col0;
    col0 = (cur <= OPT_PLAY2P);
    moveCursor = cur;
    case (ev)
      EV_UP:    moveCursor = col0 ? ((cur == OPT_PLAY1P) ? OPT_PLAY2P : cur - 3'd1)
                                  : ((cur == OPT_TOP1P) ? OPT_TOPEND : OPT_TOP1P);
      EV_DOWN:  moveCursor = col0 ? ((cur == OPT_PLAY2P) ? OPT_PLAY1P : cur + 3'd1)
                                  : ((cur == OPT_TOP1P) ? OPT_TOPEND : OPT_TOP1P);
      EV_LEFT:  if (!col0) moveCursor = (cur == OPT_TOP1P) ? OPT_PLAY1P : OPT_ENDLESS;
      EV_RIGHT: if (col0) moveCursor = (cur == OPT_PLAY1P) ? OPT_TOP1P : OPT_TOPEND;
      default:  moveCursor = cur;
    endcase
  endfunction

endpackage

// File: rtl/menu_select_controller_if.sv
// Board buttons and game-core handshake seen by the menu controller; master is the controller side.
interface menu_select_controller_if;
  import menu_pkg::*;

  logic                btn_up;
  logic                btn_down;
  logic                btn_left;
  logic                btn_right;
  logic                btn_select;
  logic                btn_back;
  logic                game_over;
  logic [MD_WIDTH-1:0] metadata;
  logic                start_pulse;
  logic [2:0]          game_mode;

  modport master (
    input  btn_up, btn_down, btn_left, btn_right, btn_select, btn_back, game_over,
    output metadata, start_pulse, game_mode
  );

  modport slave (
    output btn_up, btn_down, btn_left, btn_right, btn_select, btn_back, game_over,
    input  metadata, start_pulse, game_mode
  );

endinterface

// File: rtl/menu_select_controller_button_debouncer.sv
// One button: 2-flop sync, stable-count debounce, registered rise pulse DEBOUNCE_CYCLES+2 edges after the press.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clock,
  input  logic reset,
  input  logic rawIn,
  output logic held,
  output logic rise
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;

  logic             syncA;
  logic             syncB;
  logic             level;
  logic             levelPrev;
  logic             riseQ;
  logic [CNT_W-1:0] stableCnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      syncA     <= 1'b0;
      syncB     <= 1'b0;
      level     <= 1'b0;
      levelPrev <= 1'b0;
      riseQ     <= 1'b0;
      stableCnt <= '0;
    end else begin
      syncA     <= rawIn;
      syncB     <= syncA;
      levelPrev <= level;
      riseQ     <= level & ~levelPrev;
      // Any sample agreeing with the current level restarts the count.
      if (syncB == level) begin
        stableCnt <= '0;
      end else if (stableCnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level     <= syncB;
        stableCnt <= '0;
      end else begin
        stableCnt <= stableCnt + CNT_W'(1);
      end
    end
  end

  assign held = level & syncB;
  assign rise = riseQ;

endmodule

// File: rtl/menu_select_controller.sv
// Main-menu FSM: debounced button events move the cursor, open scores or launch a game; metadata is registered.
// A press held from edge k changes metadata at edge k+DEBOUNCE_CYCLES+3. Define MENU_AUTOREPEAT_EN for held-direction repeat.
module menu_select_controller
  import menu_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 5000000
) (
  input logic                     clock,
  input logic                     reset,
  menu_select_controller_if.master bus
);

  logic [NUM_BTN-1:0] rawBtn;
  logic [NUM_BTN-1:0] btnHeld;
  logic [NUM_BTN-1:0] btnRise;
  logic [NUM_BTN-1:0] evt;
  logic               evtVld;
  logic [2:0]         winIdx;

  menuState_e state, stateNext;
  logic [2:0] cursor, cursorNext;
  logic [2:0] screen;
  logic [2:0] gameMode;

  assign rawBtn = {bus.btn_back, bus.btn_select, bus.btn_right,
                   bus.btn_left, bus.btn_down, bus.btn_up};

  for (genvar i = 0; i < NUM_BTN; i++) begin : gBtn
    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uDebounce (
      .clock (clock),
      .reset (reset),
      .rawIn (rawBtn[i]),
      .held  (btnHeld[i]),
      .rise  (btnRise[i])
    );
  end

`ifdef MENU_AUTOREPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RPT_W   = $clog2(RPT_MAX) + 1;

  logic [RPT_W-1:0] rptCnt;
  logic [RPT_W-1:0] rptTarget;
  logic             rptActive;
  logic             rptFirst;
  logic [1:0]       rptBtn;
  logic             rptFire;
  logic             dirTaken;

  always_comb begin
    rptTarget = rptFirst ? RPT_W'(REPEAT_DELAY - 1) : RPT_W'(REPEAT_RATE - 1);
    rptFire   = rptActive && btnHeld[rptBtn] && (state == ST_MENU) && (rptCnt == rptTarget);
    evt       = btnRise;
    if (rptFire) evt[rptBtn] = 1'b1;
  end

  assign dirTaken = (state == ST_MENU) && evtVld && (winIdx <= EV_RIGHT);

  // Any acted-on direction restarts the timer; anything else disarms it.
  always_ff @(posedge clock) begin
    if (reset) begin
      rptCnt    <= '0;
      rptActive <= 1'b0;
      rptFirst  <= 1'b1;
      rptBtn    <= '0;
    end else if (dirTaken) begin
      rptActive <= 1'b1;
      rptCnt    <= '0;
      rptBtn    <= winIdx[1:0];
      rptFirst  <= !(rptFire && (winIdx[1:0] == rptBtn));
    end else if (evtVld || (state != ST_MENU) || !btnHeld[rptBtn]) begin
      rptActive <= 1'b0;
    end else begin
      rptCnt <= rptCnt + RPT_W'(1);
    end
  end
`else
  logic [NUM_BTN-1:0] unusedHeld;
  localparam bit unusedRepeatCfg = (REPEAT_DELAY > 0) && (REPEAT_RATE > 0);
  assign unusedHeld = btnHeld;
  assign evt        = btnRise;
`endif

  always_comb begin
    evtVld = |evt;
    winIdx = EV_BACK;
    for (int i = NUM_BTN - 1; i >= 0; i--) begin
      if (evt[i]) winIdx = 3'(i);
    end
  end

  always_comb begin
    stateNext  = state;
    cursorNext = cursor;
    case (state)
      ST_MENU: begin
        if (evtVld) begin
          if (winIdx == EV_SELECT) begin
            stateNext = (cursor <= OPT_PLAY2P) ? ST_LAUNCH : ST_SCORES;
          end else if (winIdx != EV_BACK) begin
            cursorNext = moveCursor(cursor, winIdx);
          end
        end
      end
      ST_LAUNCH: stateNext = ST_RUN;
      ST_RUN:    if (bus.game_over) stateNext = ST_MENU;
      ST_SCORES: if (evtVld && (winIdx == EV_SELECT || winIdx == EV_BACK)) stateNext = ST_MENU;
      default:   stateNext = ST_MENU;
    endcase
  end

  // game_mode is loaded on entry to LAUNCH so it is valid alongside start_pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= ST_MENU;
      cursor   <= OPT_PLAY1P;
      screen   <= SCR_MENU;
      gameMode <= 3'd0;
    end else begin
      state  <= stateNext;
      cursor <= cursorNext;
      screen <= screenOf(stateNext);
      if (stateNext == ST_LAUNCH) gameMode <= cursor;
    end
  end

  assign bus.metadata    = {cursor, screen, {MD_SCREEN_LSB{1'b0}}};
  assign bus.start_pulse = (state == ST_LAUNCH);
  assign bus.game_mode   = gameMode;

endmodule

// File: tb/tb_menu_select_controller.sv
// Directed bench for menu_select_controller with DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=8.
module tb_menu_select_controller;

  localparam logic [5:0] B_UP     = 6'b000001;
  localparam logic [5:0] B_DOWN   = 6'b000010;
  localparam logic [5:0] B_LEFT   = 6'b000100;
  localparam logic [5:0] B_RIGHT  = 6'b001000;
  localparam logic [5:0] B_SELECT = 6'b010000;
  localparam logic [5:0] B_BACK   = 6'b100000;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] btns = '0;
  logic       gameOver = 1'b0;
  int         checks = 0;
  int         errors = 0;
  int         pulseCount = 0;
  logic [2:0] lastPulseMode = '0;
  logic [2:0] lastPulseScreen = '0;

  menu_select_controller_if bus();

  assign bus.btn_up     = btns[0];
  assign bus.btn_down   = btns[1];
  assign bus.btn_left   = btns[2];
  assign bus.btn_right  = btns[3];
  assign bus.btn_select = btns[4];
  assign bus.btn_back   = btns[5];
  assign bus.game_over  = gameOver;

  menu_select_controller #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (20),
    .REPEAT_RATE    (8)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (bus.start_pulse === 1'b1) begin
      pulseCount++;
      lastPulseMode   = bus.game_mode;
      lastPulseScreen = bus.metadata[25:23];
    end
  end

  task automatic press(input logic [5:0] mask, input int hold);
    @(negedge clock);
    btns = mask;
    repeat (hold) @(posedge clock);
    @(negedge clock);
    btns = '0;
    repeat (12) @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    btns = '0;
    gameOver = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checks++;
    if (bus.metadata !== 29'd0) begin errors++; $display("FAIL reset_metadata: got %0h, expected 0", bus.metadata); end
    checks++;
    if (bus.start_pulse !== 1'b0) begin errors++; $display("FAIL reset_start_pulse: got %0b, expected 0", bus.start_pulse); end
    checks++;
    if (bus.game_mode !== 3'd0) begin errors++; $display("FAIL reset_game_mode: got %0d, expected 0", bus.game_mode); end
    reset = 1'b0;
  endtask

  task automatic test_debounce_timing();
    @(negedge clock);
    btns = B_DOWN;
    repeat (7) @(posedge clock);
    @(negedge clock);
    checks++;
    if (bus.metadata[28:26] !== 3'd0) begin errors++; $display("FAIL cursor_edge6: got %0d, expected 0", bus.metadata[28:26]); end
    @(posedge clock);
    @(negedge clock);
    checks++;
    if (bus.metadata[28:26] !== 3'd1) begin errors++; $display("FAIL cursor_edge7: got %0d, expected 1", bus.metadata[28:26]); end
    repeat (2) @(posedge clock);
    @(negedge clock);
    btns = '0;
    repeat (12) @(negedge clock);
    checks++;
    if (bus.metadata[28:26] !== 3'd1) begin errors++; $display("FAIL one_event_per_press: got %0d, expected 1", bus.metadata[28:26]); end
    press(B_DOWN, 10);
    checks++;
    if (bus.metadata[28:26] !== 3'd2) begin errors++; $display("FAIL down_to_2: got %0d, expected 2", bus.metadata[28:26]); end
    press(B_DOWN, 10);
    checks++;
    if (bus.metadata[28:26] !== 3'd0) begin errors++; $display("FAIL down_wrap_0: got %0d, expected 0", bus.metadata[28:26]); end
  endtask

  task automatic test_columns();
    press(B_DOWN, 10);
    press(B_DOWN, 10);
    press(B_RIGHT, 10);
    checks++;
    if (bus.metadata[28:26] !== 3'd4) begin errors++; $display("FAIL right_2_to_4: got %0d, expected 4", bus.metadata[28:26]); end
    press(B_LEFT, 10);
    checks++;
    if (bus.metadata[28:26] !== 3'd1) begin errors++; $display("FAIL left_4_to_1: got %0d, expected 1", bus.metadata[28:26]); end
    press(B_LEFT, 10);
    checks++;
    if (bus.metadata[28:26] !== 3'd1) begin errors++; $display("FAIL left_col0_stays: got %0d, expected 1", bus.metadata[28:26]); end
  endtask

  task automatic test_glitch_and_priority();
    press(B_UP, 2);
    checks++;
    if (bus.metadata !== {3'd1, 3'd0, 23'd0}) begin errors++; $display("FAIL glitch_ignored: got %0h, expected %0h", bus.metadata, {3'd1, 3'd0, 23'd0}); end
    press(B_UP | B_RIGHT, 10);
    checks++;
    if (bus.metadata[28:26] !== 3'd0) begin errors++; $display("FAIL up_beats_right: got %0d, expected 0", bus.metadata[28:26]); end
  endtask

  task automatic test_ignored_in_menu();
    press(B_BACK, 10);
    checks++;
    if (bus.metadata !== 29'd0) begin errors++; $display("FAIL back_in_menu: got %0h, expected 0", bus.metadata); end
    @(negedge clock);
    gameOver = 1'b1;
    @(negedge clock);
    gameOver = 1'b0;
    repeat (2) @(negedge clock);
    checks++;
    if (bus.metadata !== 29'd0) begin errors++; $display("FAIL game_over_in_menu: got %0h, expected 0", bus.metadata); end
  endtask

  task automatic test_launch();
    int p0;
    p0 = pulseCount;
    press(B_SELECT, 10);
    checks++;
    if (pulseCount - p0 !== 1) begin errors++; $display("FAIL launch_pulse_count: got %0d, expected 1", pulseCount - p0); end
    checks++;
    if (lastPulseMode !== 3'd0) begin errors++; $display("FAIL launch_game_mode: got %0d, expected 0", lastPulseMode); end
    checks++;
    if (lastPulseScreen !== 3'd1) begin errors++; $display("FAIL launch_screen_at_pulse: got %0d, expected 1", lastPulseScreen); end
    p0 = pulseCount;
    press(B_UP, 10);
    press(B_DOWN, 10);
    press(B_RIGHT, 10);
    press(B_SELECT, 10);
    press(B_BACK, 10);
    checks++;
    if (bus.metadata !== {3'd0, 3'd1, 23'd0}) begin errors++; $display("FAIL run_ignores_buttons: got %0h, expected %0h", bus.metadata, {3'd0, 3'd1, 23'd0}); end
    checks++;
    if (pulseCount !== p0) begin errors++; $display("FAIL run_no_relaunch: got %0d, expected %0d", pulseCount, p0); end
    @(negedge clock);
    gameOver = 1'b1;
    @(negedge clock);
    gameOver = 1'b0;
    checks++;
    if (bus.metadata !== 29'd0) begin errors++; $display("FAIL game_over_to_menu: got %0h, expected 0", bus.metadata); end
  endtask

  task automatic test_scores();
    int p0;
    press(B_RIGHT, 10);
    p0 = pulseCount;
    press(B_SELECT, 10);
    checks++;
    if (bus.metadata !== {3'd3, 3'd2, 23'd0}) begin errors++; $display("FAIL scores_enter: got %0h, expected %0h", bus.metadata, {3'd3, 3'd2, 23'd0}); end
    checks++;
    if (pulseCount !== p0) begin errors++; $display("FAIL scores_no_pulse: got %0d, expected %0d", pulseCount, p0); end
    press(B_DOWN, 10);
    checks++;
    if (bus.metadata !== {3'd3, 3'd2, 23'd0}) begin errors++; $display("FAIL scores_ignore_dir: got %0h, expected %0h", bus.metadata, {3'd3, 3'd2, 23'd0}); end
    press(B_BACK, 10);
    checks++;
    if (bus.metadata !== {3'd3, 3'd0, 23'd0}) begin errors++; $display("FAIL scores_back: got %0h, expected %0h", bus.metadata, {3'd3, 3'd0, 23'd0}); end
  endtask

  task automatic test_hold_long();
    int nEv;
    int evEdge [3];
    logic [2:0] prev;
    logic [2:0] expFinal;
    int expEv;
`ifdef MENU_AUTOREPEAT_EN
    expEv = 3;
    expFinal = 3'd0;
`else
    expEv = 1;
    expFinal = 3'd1;
`endif
    press(B_LEFT, 10);
    nEv = 0;
    evEdge = '{-1, -1, -1};
    prev = bus.metadata[28:26];
    @(negedge clock);
    btns = B_DOWN;
    for (int e = 0; e < 60; e++) begin
      @(posedge clock);
      @(negedge clock);
      if (e == 39) btns = '0;
      if (bus.metadata[28:26] !== prev) begin
        if (nEv < 3) evEdge[nEv] = e;
        nEv++;
        prev = bus.metadata[28:26];
      end
    end
    checks++;
    if (nEv !== expEv) begin errors++; $display("FAIL hold_event_count: got %0d, expected %0d", nEv, expEv); end
    checks++;
    if (evEdge[0] !== 7) begin errors++; $display("FAIL hold_first_edge: got %0d, expected 7", evEdge[0]); end
`ifdef MENU_AUTOREPEAT_EN
    checks++;
    if (evEdge[1] !== 27) begin errors++; $display("FAIL repeat_edge2: got %0d, expected 27", evEdge[1]); end
    checks++;
    if (evEdge[2] !== 35) begin errors++; $display("FAIL repeat_edge3: got %0d, expected 35", evEdge[2]); end
`endif
    checks++;
    if (bus.metadata[28:26] !== expFinal) begin errors++; $display("FAIL hold_final_cursor: got %0d, expected %0d", bus.metadata[28:26], expFinal); end
  endtask

  task automatic test_reset_mid_debounce();
    @(negedge clock);
    btns = B_DOWN;
    repeat (6) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    btns = '0;
    @(negedge clock);
    reset = 1'b0;
    repeat (15) @(negedge clock);
    checks++;
    if (bus.metadata !== 29'd0) begin errors++; $display("FAIL reset_drops_pending: got %0h, expected 0", bus.metadata); end
  endtask

  task automatic test_reset_mid_run();
    press(B_DOWN, 10);
    press(B_DOWN, 10);
    press(B_SELECT, 10);
    checks++;
    if (bus.game_mode !== 3'd2 || bus.metadata !== {3'd2, 3'd1, 23'd0}) begin
      errors++;
      $display("FAIL launch_mode2: got mode %0d md %0h, expected mode 2 md %0h", bus.game_mode, bus.metadata, {3'd2, 3'd1, 23'd0});
    end
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checks++;
    if (bus.metadata !== 29'd0 || bus.game_mode !== 3'd0 || bus.start_pulse !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_run: got md %0h mode %0d sp %0b, expected all 0", bus.metadata, bus.game_mode, bus.start_pulse);
    end
    press(B_DOWN, 10);
    checks++;
    if (bus.metadata !== {3'd1, 3'd0, 23'd0}) begin errors++; $display("FAIL menu_after_reset: got %0h, expected %0h", bus.metadata, {3'd1, 3'd0, 23'd0}); end
  endtask

  initial begin
    test_reset();
    test_debounce_timing();
    test_columns();
    test_glitch_and_priority();
    test_ignored_in_menu();
    test_launch();
    test_scores();
    test_hold_long();
    test_reset_mid_debounce();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
